// File: rtl/alu_issue_arb.sv
// Two-requester round-robin issue arbiter for the shared ALU: issue stage, one
// compute stage holding sat/ci, registered response and per-requester carry.
module alu_issue_arb #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic [5:0]            r0_op,
  input  logic                  r0_sat,
  input  logic [DATA_WIDTH-1:0] r0_x,
  input  logic [DATA_WIDTH-1:0] r0_y,
  input  logic                  r1_req,
  input  logic [5:0]            r1_op,
  input  logic                  r1_sat,
  input  logic [DATA_WIDTH-1:0] r1_x,
  input  logic [DATA_WIDTH-1:0] r1_y,
  output logic                  r0_gnt,
  output logic                  r1_gnt,
  output logic                  ps_alu_en,
  output logic                  ps_alu_log,
  output logic [1:0]            ps_alu_hc,
  output logic [2:0]            ps_alu_sc,
  output logic [DATA_WIDTH-1:0] xb_dtx,
  output logic [DATA_WIDTH-1:0] xb_dty,
  output logic                  ps_alu_sat,
  output logic                  ps_alu_ci,
  input  logic [DATA_WIDTH-1:0] alu_xb_dt,
  input  logic                  alu_ps_az,
  input  logic                  alu_ps_an,
  input  logic                  alu_ps_ac,
  input  logic                  alu_ps_av,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_dt,
  output logic                  rsp_az,
  output logic                  rsp_an,
  output logic                  rsp_ac,
  output logic                  rsp_av,
  output logic                  ac0,
  output logic                  ac1
);
  localparam int NUM_REQ = 2;
  localparam int STAGES  = 1;

  logic [NUM_REQ-1:0]                 req, sat, gnt, ac;
  logic [NUM_REQ-1:0][5:0]            op;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] x, y;
  logic [STAGES:0]                    vld_pipe;
  logic                               last, s_id, id, ci_nxt;

  assign req = {r1_req, r0_req};
  assign sat = {r1_sat, r0_sat};
  assign op  = {r1_op, r0_op};
  assign x   = {r1_x, r0_x};
  assign y   = {r1_y, r0_y};

  // last=1 means r1 was granted most recently, so r0 wins the next contention
  always_comb begin
    gnt = '0;
    if (reset) begin
      if (req[0] && (!req[1] || last)) gnt[0] = 1'b1;
      else if (req[1])                 gnt[1] = 1'b1;
    end
  end

  assign r0_gnt    = gnt[0];
  assign r1_gnt    = gnt[1];
  assign id        = gnt[1];
  assign ps_alu_en = |gnt;

  always_comb begin
    {ps_alu_log, ps_alu_hc, ps_alu_sc} = '0;
    xb_dtx = '0;
    xb_dty = '0;
    if (ps_alu_en) begin
      {ps_alu_log, ps_alu_hc, ps_alu_sc} = op[id];
      xb_dtx = x[id];
      xb_dty = y[id];
    end
  end

  // Same requester in compute stage: its carry is not stored yet, take it live
  assign ci_nxt = (vld_pipe[0] && s_id == id) ? alu_ps_ac : ac[id];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last       <= 1'b1;
      vld_pipe   <= '0;
      s_id       <= 1'b0;
      ps_alu_sat <= 1'b0;
      ps_alu_ci  <= 1'b0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:0], ps_alu_en};
      s_id       <= id;
      ps_alu_sat <= ps_alu_en & sat[id];
      ps_alu_ci  <= ps_alu_en & ci_nxt;
      if (ps_alu_en) last <= id;
    end
  end

  assign rsp_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_id <= 1'b0;
      rsp_dt <= '0;
      {rsp_az, rsp_an, rsp_ac, rsp_av} <= '0;
      ac     <= '0;
    end else if (vld_pipe[0]) begin
      rsp_id <= s_id;
      rsp_dt <= alu_xb_dt;
      {rsp_az, rsp_an, rsp_ac, rsp_av} <= {alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av};
      for (int i = 0; i < NUM_REQ; i++)
        if (s_id == 1'(i)) ac[i] <= alu_ps_ac;
    end
  end

  assign ac0 = ac[0];
  assign ac1 = ac[1];
endmodule

// File: doc/alu_issue_arb.md
# alu_issue_arb

Two-requester issue arbiter and sequencer for the shared fixed-point ALU. It grants one requester per cycle with round-robin priority and drives the ALU opcode fields, operands and enable. It holds the per-cycle saturation and carry-in controls through the ALU compute cycle, and keeps a private carry (AC) bit per requester so add/subtract-with-carry chains from different requesters never corrupt each other. It captures the ALU result and flags into a registered response tagged with the requester id.

## Interface
Parameters:
- DATA_WIDTH, 16, operand/result width; must match the ALU

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- r0_req / r1_req  in  1  request; held until granted
- r0_op / r1_op  in  6  opcode {log, hc[1:0], sc[2:0]}
- r0_sat / r1_sat  in  1  saturate this operation
- r0_x, r0_y / r1_x, r1_y  in  DATA_WIDTH  operands
- r0_gnt / r1_gnt  out  1  combinational grant; request is consumed this cycle
- ps_alu_en  out  1  ALU issue strobe (combinational, issue cycle)
- ps_alu_log, ps_alu_hc[1:0], ps_alu_sc[2:0]  out  1/2/3  opcode fields (combinational, issue cycle)
- xb_dtx, xb_dty  out  DATA_WIDTH  operands (combinational, issue cycle)
- ps_alu_sat, ps_alu_ci  out  1  registered; valid during compute cycle
- alu_xb_dt  in  DATA_WIDTH  ALU result
- alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av  in  1  ALU flags
- rsp_valid  out  1  response valid, one-cycle pulse per op
- rsp_id  out  1  requester of the response
- rsp_dt  out  DATA_WIDTH  captured result
- rsp_az, rsp_an, rsp_ac, rsp_av  out  1  captured flags
- ac0, ac1  out  1  per-requester stored carry

## Operation
- ALU contract:
  - The ALU registers opcode fields and operands at the edge where ps_alu_en=1 (the issue edge).
  - It computes combinationally in the following cycle (the compute cycle).
  - It samples ps_alu_sat and ps_alu_ci live during the compute cycle.
- Arbitration:
  - Round-robin with a last-granted pointer. Reset value is 1, so r0 wins the first contention.
  - Single requester: granted immediately.
  - Both requesting: grant the one not last granted.
  - The pointer updates only on a grant.
  - At most one grant per cycle. A grant may occur every cycle (fully pipelined).
- Issue cycle, with a grant:
  - ps_alu_en=1.
  - Opcode fields and xb_dtx/xb_dty are muxed from the winner.
- Issue cycle, no grant:
  - ps_alu_en=0.
  - Opcode fields and operands are 0.
- Pipeline registers loaded at the issue edge: valid, id, sat, ci. ps_alu_sat and ps_alu_ci are those registers.
- Carry-in selection for the op being issued:
  - Default: ci = ac[id].
  - Forwarding: if the compute-stage op is valid and has the same id, ci = live alu_ps_ac instead.
- Capture, at the end of the compute cycle when the compute stage is valid:
  - rsp_dt and the four flags are loaded from the ALU.
  - rsp_id = stage id; rsp_valid=1 for the next cycle.
  - ac[id] = alu_ps_ac for every captured op. Logical, COMP, MIN and MAX ops return AC=0 and therefore clear that requester's carry.
- When not capturing:
  - rsp_valid=0.
  - rsp_dt, rsp_id and flags hold their last values.
- An ungranted requester keeps req high; its op, sat and operands must stay stable until the grant.

## Timing
- Gnt in cycle t; ALU compute in t+1; rsp_valid in t+2. Latency is 2 cycles.
- Throughput is one op per cycle.
- Reset asserted (asynchronous):
  - Pipeline valid, rsp_valid, rsp_dt, rsp_id, rsp flags, ps_alu_sat, ps_alu_ci, ac0 and ac1 go to 0.
  - Pointer goes to 1.
  - Any in-flight op is discarded with no response.
- Grants are 0 while reset is low.
- Back-to-back same-requester carry chain: forwarding makes the second op see the first op's AC with no bubble.
- Simultaneous capture for id k and issue for id k: the issued ci equals the forwarded AC, and ac[k] also updates to that value.
- Capture for id k while issuing for the other id: no interaction.

## Test plan
- **Single add:** r0 ADD (op 000000) x=0x0003, y=0x0004 → r0_gnt in cycle 0; cycle 2 shows rsp_valid=1, rsp_id=0, rsp_dt=0x0007, all flags 0.
- **Fairness:** r0_req and r1_req both held high for 6 cycles → grants r0,r1,r0,r1,r0,r1 → responses arrive in the same order, 2 cycles later.
- **Carry chain:** r0 ADD 0xFFFF+0x0001, then next cycle r0 ADD-with-carry (op 000010) 0x0000+0x0000 → rsp_dt 0x0000 with az=1, ac=1; then rsp_dt 0x0001 with ac0=0.
- **Carry isolation:** r1 ADD 0xFFFF+0x0001 (sets ac1=1), then r0 op 000010 0x0005+0x0001 → r0 result 0x0006; ac1 stays 1.
- **Saturation:** r1 sat=1 ADD 0x7FFF+0x0001 → rsp_dt 0x7FFF, av=1; ps_alu_sat=1 during the compute cycle.
- **Reset mid-flight:** reset low during the compute cycle of an r0 op → no rsp_valid pulse; after release, ac0=ac1=0 and the first contention grants r0.
